// File: rtl/cdb_rr_arbiter_if.sv
// Bus bundle between the EX-stage functional units and the CDB arbiter.
// master: the FU/consumer side; slave: the arbiter.
interface cdb_rr_arbiter_if #(
   parameter int NUM_FU = 4,
   parameter int TAG_W  = 5,
   parameter int XLEN   = 32,
   localparam int PTR_W = $clog2(NUM_FU)
);
   logic                    squash;
   logic [NUM_FU-1:0]       fu_done;
   logic [NUM_FU*TAG_W-1:0] fu_tag;
   logic [NUM_FU*XLEN-1:0]  fu_value;
   logic [NUM_FU-1:0]       ack;
   logic                    cdb_valid;
   logic [TAG_W-1:0]        cdb_tag;
   logic [XLEN-1:0]         cdb_value;
   logic [PTR_W-1:0]        rr_ptr_dbg;

   modport master (
      output squash, fu_done, fu_tag, fu_value,
      input  ack, cdb_valid, cdb_tag, cdb_value, rr_ptr_dbg
   );

   modport slave (
      input  squash, fu_done, fu_tag, fu_value,
      output ack, cdb_valid, cdb_tag, cdb_value, rr_ptr_dbg
   );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// Round-robin Common Data Bus arbiter: one combinational one-hot ack per
// cycle, winner's tag/result broadcast on a registered CDB one edge later.
// Optional macro CDB_STARVE_GUARD_EN adds per-FU wait counters; an FU that
// has waited STARVE_LIMIT cycles overrides round-robin (lowest index first).
module cdb_rr_arbiter #(
   parameter int NUM_FU       = 4,
   parameter int TAG_W        = 5,
   parameter int XLEN         = 32,
   parameter int STARVE_LIMIT = 3,
   localparam int PTR_W       = $clog2(NUM_FU)
) (
   input  logic            clock,
   input  logic            reset,
   cdb_rr_arbiter_if.slave bus
);

   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic              cdb_valid_q, cdb_valid_d;
   logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
   logic [XLEN-1:0]   cdb_value_q, cdb_value_d;

   logic [PTR_W-1:0]  win;
   logic              any_req;
   logic              grant;
   logic [NUM_FU-1:0] ack_c;
   logic [PTR_W:0]    scan_sum;
   logic [PTR_W-1:0]  scan_idx;

`ifdef CDB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [NUM_FU-1:0][CNT_W-1:0] wait_q, wait_d;
`endif

   // Winner select: scan from rr_ptr upward with explicit wrap; the
   // descending loop lets the smallest offset from rr_ptr win last.
   always_comb begin
      win      = rr_ptr_q;
      any_req  = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = NUM_FU - 1; k >= 0; k--) begin
         scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (scan_sum >= (PTR_W+1)'(NUM_FU))
            scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
         scan_idx = scan_sum[PTR_W-1:0];
         if (bus.fu_done[scan_idx]) begin
            win     = scan_idx;
            any_req = 1'b1;
         end
      end
`ifdef CDB_STARVE_GUARD_EN
      // Starved FU overrides round-robin; lowest index assigned last wins.
      for (int i = NUM_FU - 1; i >= 0; i--) begin
         if (bus.fu_done[i] && (wait_q[i] >= CNT_W'(STARVE_LIMIT))) begin
            win     = PTR_W'(i);
            any_req = 1'b1;
         end
      end
`endif
   end

   // One-hot ack, suppressed during squash and reset.
   always_comb begin
      ack_c = '0;
      if (any_req && !bus.squash && !reset)
         ack_c[win] = 1'b1;
      grant = |ack_c;
   end

   // Next broadcast and pointer; tag/value hold when the bus is idle.
   always_comb begin
      cdb_valid_d = grant;
      cdb_tag_d   = cdb_tag_q;
      cdb_value_d = cdb_value_q;
      rr_ptr_d    = rr_ptr_q;
      if (grant) begin
         cdb_tag_d   = bus.fu_tag[win*TAG_W +: TAG_W];
         cdb_value_d = bus.fu_value[win*XLEN +: XLEN];
         rr_ptr_d    = (win == PTR_W'(NUM_FU - 1)) ? '0 : win + PTR_W'(1);
      end
   end

   // CDB and pointer registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
      end
   end

`ifdef CDB_STARVE_GUARD_EN
   // Saturating wait counters: count while waiting, clear on grant or
   // when the request drops, freeze through a squash.
   always_comb begin
      wait_d = wait_q;
      for (int i = 0; i < NUM_FU; i++) begin
         if (!bus.squash) begin
            if (!bus.fu_done[i] || ack_c[i])
               wait_d[i] = '0;
            else if (wait_q[i] < CNT_W'(STARVE_LIMIT))
               wait_d[i] = wait_q[i] + CNT_W'(1);
         end
      end
   end

   // Wait counter registers.
   always_ff @(posedge clock) begin
      if (reset) wait_q <= '0;
      else       wait_q <= wait_d;
   end
`endif

   assign bus.ack        = ack_c;
   assign bus.cdb_valid  = cdb_valid_q;
   assign bus.cdb_tag    = cdb_tag_q;
   assign bus.cdb_value  = cdb_value_q;
   assign bus.rr_ptr_dbg = rr_ptr_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed bench for cdb_rr_arbiter (NUM_FU=4, TAG_W=5, XLEN=32).
module tb_cdb_rr_arbiter;
   localparam int NUM_FU = 4;
   localparam int TAG_W  = 5;
   localparam int XLEN   = 32;

   logic clock = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   cdb_rr_arbiter_if #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) bus ();

   cdb_rr_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN), .STARVE_LIMIT(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // advance one edge, land 1ns after it
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic set_fu(input int i, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v);
      bus.fu_tag[i*TAG_W +: TAG_W] = t;
      bus.fu_value[i*XLEN +: XLEN] = v;
   endtask

   logic [3:0] exp_ack [4];
   logic [4:0] exp_tag [4];
   logic [3:0] done_seq [4];

   initial begin
      reset        = 1'b1;
      bus.squash   = 1'b0;
      bus.fu_done  = 4'b1111;
      bus.fu_tag   = '0;
      bus.fu_value = '0;
      set_fu(0, 5'd3,  32'h0000_1003);
      set_fu(1, 5'd7,  32'h0000_1007);
      set_fu(2, 5'd11, 32'h0000_100B);
      set_fu(3, 5'd15, 32'h0000_100F);

      // 1: reset with all FUs requesting
      step();
      step();
      chk("rst_ack", 64'(bus.ack), 64'h0);
      chk("rst_valid", 64'(bus.cdb_valid), 64'h0);
      chk("rst_tag", 64'(bus.cdb_tag), 64'h0);
      chk("rst_value", 64'(bus.cdb_value), 64'h0);
      chk("rst_ptr", 64'(bus.rr_ptr_dbg), 64'h0);
      reset = 1'b0;

      // 1/2: rotation over all four FUs, each dropping done after its ack
      done_seq = '{4'b1111, 4'b1110, 4'b1100, 4'b1000};
      exp_ack  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_tag  = '{5'd3, 5'd7, 5'd11, 5'd15};
      for (int k = 0; k < 4; k++) begin
         bus.fu_done = done_seq[k];
         #1;
         chk($sformatf("rot_ack%0d", k), 64'(bus.ack), 64'(exp_ack[k]));
         step();
         chk($sformatf("rot_valid%0d", k), 64'(bus.cdb_valid), 64'h1);
         chk($sformatf("rot_tag%0d", k), 64'(bus.cdb_tag), 64'(exp_tag[k]));
      end
      chk("rot_value_last", 64'(bus.cdb_value), 64'h100F);
      chk("rot_ptr_wrap", 64'(bus.rr_ptr_dbg), 64'h0);

      // 3: single requester FU2 granted back-to-back
      set_fu(2, 5'd9, 32'hDEAD_BEEF);
      bus.fu_done = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("single_ack%0d", k), 64'(bus.ack), 64'h4);
         step();
         chk($sformatf("single_valid%0d", k), 64'(bus.cdb_valid), 64'h1);
         chk($sformatf("single_value%0d", k), 64'(bus.cdb_value), 64'hDEAD_BEEF);
         chk($sformatf("single_tag%0d", k), 64'(bus.cdb_tag), 64'h9);
         chk($sformatf("single_ptr%0d", k), 64'(bus.rr_ptr_dbg), 64'h3);
      end

      // 4: squash cycle with FU0/FU1 requesting, rr_ptr at 3
      bus.fu_done = 4'b0011;
      bus.squash  = 1'b1;
      #1;
      chk("sq_ack", 64'(bus.ack), 64'h0);
      step();
      chk("sq_valid", 64'(bus.cdb_valid), 64'h0);
      chk("sq_ptr", 64'(bus.rr_ptr_dbg), 64'h3);
      chk("sq_tag_hold", 64'(bus.cdb_tag), 64'h9);
      bus.squash = 1'b0;
      #1;
      chk("post_sq_ack", 64'(bus.ack), 64'h1);
      step();
      chk("post_sq_valid", 64'(bus.cdb_valid), 64'h1);
      chk("post_sq_tag", 64'(bus.cdb_tag), 64'h3);
      chk("post_sq_ptr", 64'(bus.rr_ptr_dbg), 64'h1);
      bus.fu_done = 4'b0010;
      #1;
      chk("post_sq_ack2", 64'(bus.ack), 64'h2);
      step();
      chk("post_sq_tag2", 64'(bus.cdb_tag), 64'h7);
      chk("post_sq_ptr2", 64'(bus.rr_ptr_dbg), 64'h2);

      // 5: idle bus holds tag/value, valid low
      bus.fu_done = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("idle_ack%0d", k), 64'(bus.ack), 64'h0);
         step();
         chk($sformatf("idle_valid%0d", k), 64'(bus.cdb_valid), 64'h0);
         chk($sformatf("idle_tag%0d", k), 64'(bus.cdb_tag), 64'h7);
      end
      chk("idle_value", 64'(bus.cdb_value), 64'h1007);
      chk("idle_ptr", 64'(bus.rr_ptr_dbg), 64'h2);

`ifdef CDB_STARVE_GUARD_EN
      // 6: FU3 continuously waiting while FU0-2 re-request every cycle
      reset = 1'b1;
      step();
      reset = 1'b0;
      bus.fu_done = 4'b1111;
      begin
         int waited;
         bit got;
         waited = 0;
         got = 1'b0;
         while (!got && waited < 8) begin
            #1;
            waited++;
            if (bus.ack[3]) got = 1'b1;
            step();
         end
         chk("starve_granted", 64'(got), 64'h1);
         chk("starve_bound", 64'(waited <= 4), 64'h1);
         chk("starve_tag", 64'(bus.cdb_tag), 64'd15);
         chk("starve_cnt_clr", 64'(dut.wait_q[3]), 64'h0);
      end
      bus.fu_done = 4'b0000;
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   // Independent watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
